// File: rtl/mio_arbiter.sv
// Two-master memory/IO arbiter: round-robin grant of CPU or AUX onto one shared bus,
// one transaction at a time, with an ack timeout that returns ERR_DATA and pulses bus_err.
module mio_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic [31:0] aux_rdata,
  output logic        aux_ready,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_AUX  = 2'd2;
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [1:0]  owner_q;
  logic        lastAux_q;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cpuRdata_q;
  logic [31:0] auxRdata_q;
  logic        cpuReady_q;
  logic        auxReady_q;
  logic        busErr_q;
  logic        memCs_q;
  logic        memWe_q;
  logic        grantAux_d;
  logic [31:0] respData_d;

  // On a tie AUX wins only if the CPU was the last master served.
  always_comb begin
    grantAux_d = aux_req && (!cpu_req || !lastAux_q);
    respData_d = mem_ack ? mem_rdata : ERR_DATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      lastAux_q  <= 1'b1;
      cnt_q      <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cpuRdata_q <= 32'd0;
      auxRdata_q <= 32'd0;
      cpuReady_q <= 1'b0;
      auxReady_q <= 1'b0;
      busErr_q   <= 1'b0;
      memCs_q    <= 1'b0;
      memWe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req || aux_req) begin
            owner_q   <= grantAux_d ? OWN_AUX : OWN_CPU;
            lastAux_q <= grantAux_d;
            we_q      <= grantAux_d ? aux_we    : cpu_we;
            addr_q    <= grantAux_d ? aux_addr  : cpu_addr;
            wdata_q   <= grantAux_d ? aux_wdata : cpu_wdata;
            memCs_q   <= 1'b1;
            memWe_q   <= grantAux_d ? aux_we : cpu_we;
            cnt_q     <= 8'd0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack || (cnt_q == LAST_CNT)) begin
            memCs_q  <= 1'b0;
            memWe_q  <= 1'b0;
            busErr_q <= !mem_ack;
            if (owner_q == OWN_CPU) begin
              cpuReady_q <= 1'b1;
              if (!we_q) cpuRdata_q <= respData_d;
            end else begin
              auxReady_q <= 1'b1;
              if (!we_q) auxRdata_q <= respData_d;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          cpuReady_q <= 1'b0;
          auxReady_q <= 1'b0;
          busErr_q   <= 1'b0;
          owner_q    <= OWN_NONE;
          cnt_q      <= 8'd0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpuRdata_q;
  assign aux_rdata = auxRdata_q;
  assign cpu_ready = cpuReady_q;
  assign aux_ready = auxReady_q;
  assign bus_err   = busErr_q;
  assign mem_cs    = memCs_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;

endmodule
